face_seq_ctrl: RTL and testbench

FACE_SEQ_CTRL -- requirements
Module: face_seq_ctrl

---
 rtl/face_pkg.sv | 24 ++
 rtl/face_seq_timeout.sv | 32 +++
 rtl/face_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_face_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/face_pkg.sv
// Shared definitions for the face-detection frame sequencer: state encoding,
// default image geometry and small state-decode helpers.
package face_pkg;

    localparam int unsigned IMG_WIDTH_DEF      = 256;
    localparam int unsigned IMG_HEIGHT_DEF     = 256;
    localparam int unsigned DEPTH_DEF          = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_FIN = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } face_state_e;

    // The filter keeps processing from the end of the load until DONE/ERROR.
    function automatic logic drives_process(input face_state_e s);
        return (s == ST_WAIT_FIN) || (s == ST_STREAM);
    endfunction

endpackage

// File: rtl/face_seq_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module face_seq_timeout
    import face_pkg::*;
#(
    parameter int unsigned CW = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          expired
);

    logic [CW-1:0] count_r;

    // Count register: load has priority over decrement, saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == '0);

endmodule

// File: rtl/face_seq_ctrl.sv
// Frame sequencer: reads a frame from the buffer into the filter, waits for
// the filter to finish, then captures the mask stream and centroid.
module face_seq_ctrl
    import face_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT     = IMG_HEIGHT_DEF,
    parameter int unsigned DEPTH          = DEPTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int unsigned AW            = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_short,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [DEPTH-1:0] rd_r,
    input  logic [DEPTH-1:0] rd_g,
    input  logic [DEPTH-1:0] rd_b,
    output logic [DEPTH-1:0] pix_r,
    output logic [DEPTH-1:0] pix_g,
    output logic [DEPTH-1:0] pix_b,
    output logic             filt_enable,
    output logic             filt_enable_process,
    input  logic [DEPTH-1:0] filt_mask,
    input  logic [7:0]       filt_cx,
    input  logic [7:0]       filt_cy,
    input  logic             filt_centroid_ready,
    input  logic             filt_finish,
    output logic             mask_valid,
    output logic [DEPTH-1:0] mask_data,
    output logic [AW-1:0]    mask_index,
    output logic [7:0]       centroid_x,
    output logic [7:0]       centroid_y,
    output logic             centroid_valid
);

    localparam int unsigned TCW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] N_CNT    = (AW+1)'(IMG_WIDTH * IMG_HEIGHT);
    // Read pipeline is two deep, so LOAD ends two cycles after the last address.
    localparam logic [AW:0] LOAD_END = (AW+1)'(IMG_WIDTH * IMG_HEIGHT + 1);
    localparam logic [TCW-1:0] TO_LOAD = TCW'(TIMEOUT_CYCLES - 1);

    face_state_e state_r, state_next_s;
    logic [AW:0] load_cnt_r, load_cnt_next_s;
    logic [AW:0] mask_cnt_r;
    logic        start_ok_s, set_to_s, set_sh_s;
    logic        rd_issue_s, pix_take_s, mask_take_s;
    logic        to_load_s, to_dec_s, to_expired_s;

    logic             busy_r, done_r, err_to_r, err_sh_r;
    logic             rd_en_r, rd_vld_d1_r, filt_enable_r, proc_r;
    logic [AW-1:0]    rd_addr_r;
    logic [DEPTH-1:0] pix_r_r, pix_g_r, pix_b_r;
    logic             mask_valid_r;
    logic [DEPTH-1:0] mask_data_r;
    logic [AW-1:0]    mask_index_r;
    logic [7:0]       cen_x_r, cen_y_r;
    logic             cen_valid_r;

    face_seq_timeout #(.CW(TCW)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load_s),
        .load_val (TO_LOAD),
        .dec      (to_dec_s),
        .expired  (to_expired_s)
    );

    // Next-state logic; abort outranks every other condition.
    always_comb begin
        state_next_s    = state_r;
        load_cnt_next_s = load_cnt_r;
        start_ok_s      = 1'b0;
        set_to_s        = 1'b0;
        set_sh_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    state_next_s    = ST_LOAD;
                    load_cnt_next_s = '0;
                    start_ok_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    load_cnt_next_s = load_cnt_r + (AW+1)'(1);
                    if (load_cnt_r == LOAD_END) begin
                        state_next_s = ST_WAIT_FIN;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end
            end
            ST_WAIT_FIN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (filt_finish && filt_centroid_ready) begin
                    state_next_s = ST_STREAM;
                end else if (to_expired_s) begin
                    state_next_s = ST_ERROR;
                    set_to_s     = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_FIN;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (!filt_finish) begin
                    if (mask_cnt_r == N_CNT) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERROR;
                        set_sh_s     = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            ST_ERROR: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    assign rd_issue_s  = (state_next_s == ST_LOAD) && (load_cnt_next_s < N_CNT);
    assign pix_take_s  = rd_vld_d1_r && (state_next_s == ST_LOAD);
    assign mask_take_s = (state_r == ST_STREAM) && !abort && filt_finish &&
                         filt_centroid_ready && (mask_cnt_r < N_CNT);
    assign to_load_s   = (state_next_s == ST_WAIT_FIN) && (state_r != ST_WAIT_FIN);
    assign to_dec_s    = (state_r == ST_WAIT_FIN);

    // State, counters, control outputs and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            load_cnt_r    <= '0;
            mask_cnt_r    <= '0;
            rd_en_r       <= 1'b0;
            rd_addr_r     <= '0;
            rd_vld_d1_r   <= 1'b0;
            filt_enable_r <= 1'b0;
            proc_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_to_r      <= 1'b0;
            err_sh_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            load_cnt_r    <= load_cnt_next_s;
            rd_en_r       <= rd_issue_s;
            rd_addr_r     <= rd_issue_s ? load_cnt_next_s[AW-1:0] : '0;
            rd_vld_d1_r   <= rd_en_r && (state_next_s == ST_LOAD);
            filt_enable_r <= pix_take_s;
            proc_r        <= drives_process(state_next_s);
            busy_r        <= (state_next_s != ST_IDLE);
            done_r        <= (state_next_s == ST_DONE);
            if (start_ok_s) begin
                mask_cnt_r <= '0;
                err_to_r   <= 1'b0;
                err_sh_r   <= 1'b0;
            end else begin
                mask_cnt_r <= mask_take_s ? mask_cnt_r + (AW+1)'(1) : mask_cnt_r;
                err_to_r   <= err_to_r | set_to_s;
                err_sh_r   <= err_sh_r | set_sh_s;
            end
        end
    end

    // Datapath registers: pixel pass-through, mask capture, centroid latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r_r      <= '0;
            pix_g_r      <= '0;
            pix_b_r      <= '0;
            mask_valid_r <= 1'b0;
            mask_data_r  <= '0;
            mask_index_r <= '0;
            cen_x_r      <= 8'd0;
            cen_y_r      <= 8'd0;
            cen_valid_r  <= 1'b0;
        end else begin
            if (pix_take_s) begin
                pix_r_r <= rd_r;
                pix_g_r <= rd_g;
                pix_b_r <= rd_b;
            end
            mask_valid_r <= mask_take_s;
            if (mask_take_s) begin
                mask_data_r  <= filt_mask;
                mask_index_r <= mask_cnt_r[AW-1:0];
            end
            // Only the first centroid report of a frame is kept.
            if (start_ok_s) begin
                cen_valid_r <= 1'b0;
            end else if ((state_r != ST_IDLE) && filt_centroid_ready && !cen_valid_r) begin
                cen_x_r     <= filt_cx;
                cen_y_r     <= filt_cy;
                cen_valid_r <= 1'b1;
            end
        end
    end

    assign busy                = busy_r;
    assign done                = done_r;
    assign err_timeout         = err_to_r;
    assign err_short           = err_sh_r;
    assign rd_en               = rd_en_r;
    assign rd_addr             = rd_addr_r;
    assign pix_r               = pix_r_r;
    assign pix_g               = pix_g_r;
    assign pix_b               = pix_b_r;
    assign filt_enable         = filt_enable_r;
    assign filt_enable_process = proc_r;
    assign mask_valid          = mask_valid_r;
    assign mask_data           = mask_data_r;
    assign mask_index          = mask_index_r;
    assign centroid_x          = cen_x_r;
    assign centroid_y          = cen_y_r;
    assign centroid_valid      = cen_valid_r;

endmodule

// File: tb/tb_face_seq_ctrl.sv
// Bench for face_seq_ctrl on a 4x4 frame: table-driven frame scenarios plus
// hand-written abort and mid-frame reset sequences.
module tb_face_seq_ctrl;

    localparam int N  = 16;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       busy, done, err_timeout, err_short;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_r = 8'd0, rd_g = 8'd0, rd_b = 8'd0;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       filt_enable, filt_enable_process;
    logic [7:0] filt_mask = 8'd0, filt_cx = 8'd0, filt_cy = 8'd0;
    logic       filt_centroid_ready = 1'b0, filt_finish = 1'b0;
    logic       mask_valid;
    logic [7:0] mask_data;
    logic [3:0] mask_index;
    logic [7:0] centroid_x, centroid_y;
    logic       centroid_valid;

    face_seq_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DEPTH(8), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_short(err_short),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .filt_enable(filt_enable), .filt_enable_process(filt_enable_process),
        .filt_mask(filt_mask), .filt_cx(filt_cx), .filt_cy(filt_cy),
        .filt_centroid_ready(filt_centroid_ready), .filt_finish(filt_finish),
        .mask_valid(mask_valid), .mask_data(mask_data), .mask_index(mask_index),
        .centroid_x(centroid_x), .centroid_y(centroid_y), .centroid_valid(centroid_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Filter model state: centroid after 5 process cycles (changing to a
    // different value 3 cycles later), finish after 10; the first finish
    // cycle is the WAIT_FIN handshake, each later one carries mask (j*3).
    int proc_cnt, fin_j, fin_len;
    bit model_on = 1'b0;

    typedef struct {
        string name;
        int    fin_len;
        int    exp_done;
        int    exp_masks;
        bit    exp_to;
        bit    exp_sh;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic       en_q;
        logic [3:0] a_q;
        en_q = rd_en;
        a_q  = rd_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (en_q) begin
            rd_r = {4'd0, a_q};
            rd_g = {4'd0, a_q} + 8'd16;
            rd_b = ~{4'd0, a_q};
        end
        if (filt_enable_process) proc_cnt++;
        if (model_on && busy && proc_cnt >= 5) begin
            filt_centroid_ready = 1'b1;
            filt_cx = (proc_cnt >= 8) ? 8'd99 : 8'd37;
            filt_cy = (proc_cnt >= 8) ? 8'd11 : 8'd200;
        end else begin
            filt_centroid_ready = 1'b0;
        end
        if (model_on && proc_cnt >= 10 && fin_j < fin_len) begin
            filt_finish = 1'b1;
            filt_mask   = 8'(fin_j * 3);
            fin_j++;
        end else begin
            filt_finish = 1'b0;
        end
    endtask

    task automatic model_init(input int fl);
        proc_cnt = 0;
        fin_j    = 0;
        fin_len  = fl;
        model_on = 1'b1;
        filt_centroid_ready = 1'b0;
        filt_finish = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, err_timeout, err_short, rd_en, rd_addr,
                            filt_enable, filt_enable_process, mask_valid, centroid_valid}, 0);
        chk({tag, "_pix"}, {pix_r, pix_g, pix_b}, 0);
        chk({tag, "_res"}, {mask_data, mask_index, centroid_x, centroid_y}, 0);
    endtask

    task automatic run_frame(input vec_t v);
        int issue[16];
        int addr_exp = 0, pix_exp = 0, masks = 0, dones = 0, proc_tot = 0;
        int last_pix = -1, first_proc = -1, err_cyc = -1, idle_cyc = -1;
        model_init(v.fin_len);
        foreach (issue[i]) issue[i] = -100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rd_en) begin
                chk({v.name, "_rd_addr"}, rd_addr, addr_exp);
                issue[rd_addr] = cyc;
                addr_exp++;
            end
            if (filt_enable) begin
                chk({v.name, "_pix_r"}, pix_r, pix_exp);
                chk({v.name, "_pix_g"}, pix_g, pix_exp + 16);
                chk({v.name, "_pix_lat"}, cyc - issue[pix_r[3:0]], 2);
                pix_exp++;
                last_pix = cyc;
            end
            if (filt_enable_process) begin
                proc_tot++;
                if (first_proc < 0) first_proc = cyc;
            end
            if (mask_valid) begin
                chk({v.name, "_mask_index"}, mask_index, masks);
                chk({v.name, "_mask_data"}, mask_data, (masks + 1) * 3);
                masks++;
            end
            if (done) dones++;
            if (err_timeout && err_cyc < 0) err_cyc = cyc;
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            tick();
        end
        chk({v.name, "_frame_ended"}, idle_cyc >= 0, 1);
        chk({v.name, "_pixels"}, pix_exp, N);
        chk({v.name, "_proc_rise"}, first_proc - last_pix, 1);
        chk({v.name, "_done_cnt"}, dones, v.exp_done);
        chk({v.name, "_mask_cnt"}, masks, v.exp_masks);
        chk({v.name, "_err_timeout"}, err_timeout, v.exp_to);
        chk({v.name, "_err_short"}, err_short, v.exp_sh);
        if (v.exp_to) begin
            chk({v.name, "_wait_cycles"}, proc_tot, 50);
            chk({v.name, "_busy_fall"}, (idle_cyc - err_cyc) <= 2, 1);
        end
        model_on = 1'b0;
        filt_centroid_ready = 1'b0;
        filt_finish = 1'b0;
        repeat (3) tick();
        chk({v.name, "_cen_x"}, centroid_x, 37);
        chk({v.name, "_cen_y"}, centroid_y, 200);
        chk({v.name, "_cen_valid_idle"}, centroid_valid, 1);
        chk({v.name, "_idle_proc"}, filt_enable_process, 0);
    endtask

    initial begin
        bit found;
        int dones;
        tbl[0] = '{"normal",   17, 1, 16, 1'b0, 1'b0};
        tbl[1] = '{"overrun",  20, 1, 16, 1'b0, 1'b0};
        tbl[2] = '{"short",    10, 0,  9, 1'b0, 1'b1};
        tbl[3] = '{"timeout",   0, 0,  0, 1'b1, 1'b0};
        tbl[4] = '{"recover",  17, 1, 16, 1'b0, 1'b0};

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_rd_en", rd_en, 0);

        // abort while LOAD is issuing pixel 7
        model_init(17);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_en && rd_addr == 4'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached_px7", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outputs", {rd_en, filt_enable, filt_enable_process, mask_valid, busy}, 0);
        run_frame(tbl[0]);

        // asynchronous reset during STREAM
        model_init(17);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mask_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_reached_stream", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_on = 1'b0;
        dones = 0;
        repeat (2) begin
            tick();
            dones += int'(done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            dones += int'(done);
        end
        chk("rst_no_done", dones, 0);
        run_frame(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
